add_sub_seq: RTL

Parametrised, sequential add/subtract unit for the ALU datapath. It accepts a WIDTH-bit operand pair and processes the operation DIGIT bits per clock, least-significant slice first, carrying the carry or borrow between slices. Results come back as a registered sum/difference with carry/borrow, signed-overflow and zero flags. The unit uses valid/ready handshakes on input and output, so it slots between the operand register file and the ALU result mux.

---
 rtl/add_sub_pkg.sv | 13 +
 rtl/add_sub_digit.sv | 18 +
 rtl/add_sub_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/add_sub_pkg.sv
// rtl/add_sub_pkg.sv - shared op encoding and FSM state type for add_sub_seq
package add_sub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_sub_digit.sv
// rtl/add_sub_digit.sv - combinational DIGIT-bit adder slice with carry in/out
module add_sub_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             cin,
    output logic [DIGIT-1:0] sum,
    output logic             cout
);

    logic [DIGIT:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, cin};
    assign sum   = total[DIGIT-1:0];
    assign cout  = total[DIGIT];

endmodule

// File: rtl/add_sub_seq.sv
// rtl/add_sub_seq.sv - digit-serial add/subtract unit, LS slice first, valid/ready on both sides
// Subtraction runs as A + ~B + ~borrow_in; the final carry is inverted back into a borrow.
module add_sub_seq
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Out,
    output logic             Carry_out,
    output logic             Overflow,
    output logic             Zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam logic [SW-1:0] LAST_STEP = SW'(N - 1);

    state_e           state_q, state_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             op_q, op_d;
    logic             carry_q, carry_d;

    logic [DIGIT-1:0] slice_a, slice_b, slice_sum;
    logic             slice_cout;

    // One shared slice adder; the step counter selects which digit it sees.
    assign slice_a = a_q[int'(step_q) * DIGIT +: DIGIT];
    assign slice_b = b_q[int'(step_q) * DIGIT +: DIGIT];

    add_sub_digit #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (carry_q),
        .sum  (slice_sum),
        .cout (slice_cout)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        a_d     = a_q;
        b_d     = b_q;
        out_d   = out_q;
        op_d    = op_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = (op == OP_ADD) ? B : ~B;
                    op_d    = op;
                    carry_d = (op == OP_ADD) ? Carry_in : ~Carry_in;
                    step_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_d[int'(step_q) * DIGIT +: DIGIT] = slice_sum;
                carry_d = slice_cout;
                step_d  = step_q + 1'b1;
                if (step_q == LAST_STEP) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            step_q  <= '0;
            a_q     <= '0;
            b_q     <= '0;
            out_q   <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            a_q     <= a_d;
            b_q     <= b_d;
            out_q   <= out_d;
            op_q    <= op_d;
            carry_q <= carry_d;
        end
    end

    // Flags are forced low outside DONE so they read 0 after reset, not a stale Zero.
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign Out       = out_q;
    assign Carry_out = out_valid & ((op_q == OP_SUB) ? ~carry_q : carry_q);
    assign Overflow  = out_valid & (a_q[WIDTH-1] == b_q[WIDTH-1]) & (out_q[WIDTH-1] != a_q[WIDTH-1]);
    assign Zero      = out_valid & (out_q == '0);

endmodule
